// File: rtl/cv_bitmanip_exu.sv
`default_nettype none
// ============================================================================
// Module   : cv_bitmanip_exu
// Brief    : Elastically pipelined CV32E40P bit-manipulation execution unit.
// Revision : 1.0
// ============================================================================
module cv_bitmanip_exu #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [XLEN-1:0]  rd_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int         L      = $clog2(XLEN);
    localparam logic [L:0] XLEN_L = (L+1)'(XLEN);
    localparam logic [L:0] ONE_L  = (L+1)'(1);

    typedef enum logic [3:0] {
        OP_EXTRACT, OP_EXTRACTU, OP_INSERT, OP_BCLR, OP_BSET,
        OP_ROR, OP_FF1, OP_FL1, OP_CLB, OP_CNT, OP_ILL
    } op_e;

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    op_e          op;
    logic [L-1:0] len;
    logic [L-1:0] pos;
    logic         unused_bits;

    assign opcode      = instr_i[6:0];
    assign funct3      = instr_i[14:12];
    assign funct7      = instr_i[31:25];
    assign unused_bits = ^{instr_i[19:15], instr_i[11:7], rs2_i[XLEN-1:2*L]};

    always_comb begin
        op  = OP_ILL;
        len = rs2_i[2*L-1:L];
        pos = rs2_i[L-1:0];
        if (opcode == 7'h2B && funct3 == 3'b011) begin
            case (funct7)
                7'b0011000: op = OP_EXTRACT;
                7'b0011001: op = OP_EXTRACTU;
                7'b0011010: op = OP_INSERT;
                7'b0011100: op = OP_BCLR;
                7'b0011101: op = OP_BSET;
                7'b0100000: op = OP_ROR;
                7'b0100001: op = OP_FF1;
                7'b0100010: op = OP_FL1;
                7'b0100011: op = OP_CLB;
                7'b0100100: op = OP_CNT;
                default:    op = OP_ILL;
            endcase
        end else if (opcode == 7'h5B) begin
            len = L'(instr_i[29:25]);
            pos = L'(instr_i[24:20]);
            case ({instr_i[31:30], funct3})
                5'b00_000: op = OP_EXTRACT;
                5'b01_000: op = OP_EXTRACTU;
                5'b10_000: op = OP_INSERT;
                5'b00_001: op = OP_BCLR;
                5'b01_001: op = OP_BSET;
                default:   op = OP_ILL;
            endcase
        end
    end

    // Field top saturates at XLEN-1: bits past the MSB are dropped, never wrapped.
    logic [L:0]      end_pos;
    logic [L-1:0]    hi;
    logic [XLEN-1:0] ones, mask, field, field_ones;
    logic [L-1:0]    ror_amt;

    assign end_pos    = {1'b0, pos} + {1'b0, len};
    assign hi         = (end_pos > XLEN_L - ONE_L) ? L'(XLEN-1) : end_pos[L-1:0];
    assign ones       = '1;
    assign mask       = (ones >> (L'(XLEN-1) - hi)) & (ones << pos);
    assign field      = (rs1_i & mask) >> pos;
    assign field_ones = mask >> pos;
    assign ror_amt    = rs2_i[L-1:0];

    logic [L:0] ff1, fl1, clb, cnt;
    logic       run;

    always_comb begin
        ff1 = XLEN_L;
        fl1 = XLEN_L;
        cnt = '0;
        clb = '0;
        run = 1'b1;
        for (int i = XLEN-1; i >= 0; i--) begin
            if (rs1_i[i]) ff1 = (L+1)'(i);
            cnt = cnt + (L+1)'(rs1_i[i]);
            if (run && (rs1_i[i] == rs1_i[XLEN-1])) clb = clb + ONE_L;
            else                                     run = 1'b0;
        end
        for (int i = 0; i < XLEN; i++) begin
            if (rs1_i[i]) fl1 = (L+1)'(i);
        end
        if (rs1_i == '0) clb = '0;
        else             clb = clb - ONE_L;
    end

    logic [XLEN-1:0] calc_res;
    logic            calc_ill;

    always_comb begin
        calc_res = '0;
        calc_ill = 1'b0;
        case (op)
            OP_EXTRACT:  calc_res = field | (rs1_i[hi] ? ~field_ones : '0);
            OP_EXTRACTU: calc_res = field;
            OP_INSERT:   calc_res = (rd_i & ~mask) | ((rs1_i << pos) & mask);
            OP_BCLR:     calc_res = rs1_i & ~mask;
            OP_BSET:     calc_res = rs1_i | mask;
            OP_ROR:      calc_res = (rs1_i >> ror_amt) | (rs1_i << (XLEN_L - {1'b0, ror_amt}));
            OP_FF1:      calc_res = XLEN'(ff1);
            OP_FL1:      calc_res = XLEN'(fl1);
            OP_CLB:      calc_res = XLEN'(clb);
            OP_CNT:      calc_res = XLEN'(cnt);
            default:     calc_ill = 1'b1;
        endcase
    end

    logic [STAGES-1:0] vld, rdy, up_vld, ill_q, up_ill;
    logic [XLEN-1:0]   res_q  [STAGES];
    logic [XLEN-1:0]   up_res [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  up_tag [STAGES];
    logic              full;

    // A stage is ready unless it and every stage downstream of it is occupied.
    always_comb begin
        full = 1'b1;
        rdy  = '0;
        for (int k = STAGES-1; k >= 0; k--) begin
            full   = full & vld[k];
            rdy[k] = out_ready_i | ~full;
        end
    end

    always_comb begin
        up_vld    = '0;
        up_ill    = '0;
        up_vld[0] = in_valid_i;
        up_ill[0] = calc_ill;
        up_res[0] = calc_res;
        up_tag[0] = tag_i;
        for (int k = 1; k < STAGES; k++) begin
            up_vld[k] = vld[k-1];
            up_ill[k] = ill_q[k-1];
            up_res[k] = res_q[k-1];
            up_tag[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld   <= '0;
            ill_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else if (flush_i) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= up_vld[k];
                    if (up_vld[k]) begin
                        res_q[k] <= up_res[k];
                        ill_q[k] <= up_ill[k];
                        tag_q[k] <= up_tag[k];
                    end
                end
            end
        end
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = vld[STAGES-1];
    assign result_o    = res_q[STAGES-1];
    assign illegal_o   = ill_q[STAGES-1];
    assign tag_o       = tag_q[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_cv_bitmanip_exu.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv_bitmanip_exu
// Brief    : Scoreboard bench for cv_bitmanip_exu against a bit-level model.
// Revision : 1.0
// ============================================================================
module tb_cv_bitmanip_exu;
    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [31:0]      instr_i = '0;
    logic [XLEN-1:0]  rs1_i = '0;
    logic [XLEN-1:0]  rs2_i = '0;
    logic [XLEN-1:0]  rd_i = '0;
    logic [TAG_W-1:0] tag_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [XLEN-1:0]  result_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;

    cv_bitmanip_exu #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .instr_i(instr_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .illegal_o(illegal_o), .tag_o(tag_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        logic [4:0]  tag;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ready_mode = 0;   // 0 always ready, 1 random, 2 pattern 1,0,0, 3 never
    int   rr_idx = 0;

    localparam logic [6:0] R_F7 [10] = '{7'b0011000, 7'b0011001, 7'b0011010, 7'b0011100,
                                        7'b0011101, 7'b0100000, 7'b0100001, 7'b0100010,
                                        7'b0100011, 7'b0100100};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walks the field bit by bit; result {illegal, value}.
    function automatic logic [32:0] model(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] rd);
        int          kind;
        int          len;
        int          pos;
        int          hi;
        int          n;
        logic [31:0] r;
        logic [63:0] d;
        kind = -1;
        len  = 0;
        pos  = 0;
        r    = '0;
        if (ins[6:0] == 7'h2B && ins[14:12] == 3'b011) begin
            len = int'(b[9:5]);
            pos = int'(b[4:0]);
            for (int i = 0; i < 10; i++) if (ins[31:25] == R_F7[i]) kind = i;
        end else if (ins[6:0] == 7'h5B) begin
            len = int'(ins[29:25]);
            pos = int'(ins[24:20]);
            case ({ins[31:30], ins[14:12]})
                5'b00_000: kind = 0;
                5'b01_000: kind = 1;
                5'b10_000: kind = 2;
                5'b00_001: kind = 3;
                5'b01_001: kind = 4;
                default:   kind = -1;
            endcase
        end
        hi = (pos + len > 31) ? 31 : pos + len;
        case (kind)
            0, 1: begin
                for (int i = pos; i <= hi; i++) r[i-pos] = a[i];
                if (kind == 0) for (int j = hi - pos + 1; j < 32; j++) r[j] = a[hi];
            end
            2: begin
                r = rd;
                for (int i = pos; i <= hi; i++) r[i] = a[i-pos];
            end
            3: begin
                r = a;
                for (int i = pos; i <= hi; i++) r[i] = 1'b0;
            end
            4: begin
                r = a;
                for (int i = pos; i <= hi; i++) r[i] = 1'b1;
            end
            5: begin
                d = {a, a} >> b[4:0];
                r = d[31:0];
            end
            6: begin
                r = 32'd32;
                for (int i = 31; i >= 0; i--) if (a[i]) r = 32'(i);
            end
            7: begin
                r = 32'd32;
                for (int i = 0; i < 32; i++) if (a[i]) r = 32'(i);
            end
            8: begin
                if (a != 0) begin
                    n = 0;
                    for (int i = 31; i >= 0 && a[i] == a[31]; i--) n++;
                    r = 32'(n - 1);
                end
            end
            9: r = 32'($countones(a));
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, r};
    endfunction

    initial begin : ready_gen
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: out_ready_i = 1'b1;
                1: out_ready_i = ($urandom_range(0, 3) != 0);
                2: begin
                    out_ready_i = (rr_idx % 3 == 0);
                    rr_idx++;
                end
                default: out_ready_i = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        exp_t        e;
        logic        stalled;
        logic [31:0] h_res;
        logic        h_ill;
        logic [4:0]  h_tag;
        stalled = 1'b0;
        h_res = '0;
        h_ill = 1'b0;
        h_tag = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", out_valid_o, 1'b1);
                    check("stall_result", result_o, h_res);
                    check("stall_illegal", illegal_o, h_ill);
                    check("stall_tag", tag_o, h_tag);
                end
                if (out_valid_o && out_ready_i) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got result %0h with no op outstanding", result_o);
                    end else begin
                        e = sb.pop_front();
                        check("result", result_o, e.res);
                        check("illegal", illegal_o, e.ill);
                        check("tag", tag_o, e.tag);
                        if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), STAGES);
                    end
                end
                stalled = out_valid_o && !out_ready_i && !flush_i;
                h_res   = result_o;
                h_ill   = illegal_o;
                h_tag   = tag_o;
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] rd, input logic [4:0] tag);
        logic [32:0] m;
        exp_t        e;
        int          waited;
        bit          done;
        waited = 0;
        done   = 0;
        @(negedge clk);
        instr_i    = ins;
        rs1_i      = a;
        rs2_i      = b;
        rd_i       = rd;
        tag_i      = tag;
        in_valid_i = 1'b1;
        while (!done) begin
            #1;
            check("in_ready", in_ready_o, out_ready_i || (sb.size() < STAGES));
            if (in_ready_o) begin
                m         = model(ins, a, b, rd);
                e.res     = m[31:0];
                e.ill     = m[32];
                e.tag     = tag;
                e.acc_cyc = cyc;
                e.chk_lat = (ready_mode == 0);
                sb.push_back(e);
                done = 1;
            end else if (waited > 100) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: in_ready_o stayed 0 for %0d cycles", waited);
                done = 1;
            end else begin
                waited++;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        in_valid_i = 1'b0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        idle(2);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h1 << $urandom_range(0, 31);
            3:       return ~(32'h1 << $urandom_range(0, 31));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [1:0]  sel;
        int          k;
        w = $urandom();
        k = $urandom_range(0, 9);
        if (k < 5) begin
            w[31:25] = R_F7[$urandom_range(0, 9)];
            w[14:12] = 3'b011;
            w[6:0]   = 7'h2B;
        end else if (k < 9) begin
            sel      = 2'($urandom_range(0, 2));
            w[31:30] = sel;
            w[14:12] = 3'($urandom_range(0, 1));
            w[6:0]   = 7'h5B;
        end
        return w;
    endfunction

    localparam logic [31:0] I_CNT  = {7'b0100100, 5'd0, 5'd1, 3'b011, 5'd2, 7'h2B};
    localparam logic [31:0] I_EXT  = {2'b00, 5'd7, 5'd4, 5'd1, 3'b000, 5'd2, 7'h5B};
    localparam logic [31:0] I_EXTU = {2'b01, 5'd7, 5'd4, 5'd1, 3'b000, 5'd2, 7'h5B};
    localparam logic [31:0] I_INS  = {2'b10, 5'd3, 5'd30, 5'd1, 3'b000, 5'd2, 7'h5B};
    localparam logic [31:0] I_BCLR = {2'b00, 5'd31, 5'd0, 5'd1, 3'b001, 5'd2, 7'h5B};
    localparam logic [31:0] I_FF1  = {7'b0100001, 5'd0, 5'd1, 3'b011, 5'd2, 7'h2B};
    localparam logic [31:0] I_FL1  = {7'b0100010, 5'd0, 5'd1, 3'b011, 5'd2, 7'h2B};
    localparam logic [31:0] I_CLB  = {7'b0100011, 5'd0, 5'd1, 3'b011, 5'd2, 7'h2B};
    localparam logic [31:0] I_ROR  = {7'b0100000, 5'd0, 5'd1, 3'b011, 5'd2, 7'h2B};
    localparam logic [31:0] I_BAD  = {7'b0101000, 5'd0, 5'd1, 3'b011, 5'd2, 7'h2B};

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid_o, 1'b0);
        check("reset_result", result_o, 32'h0);
        check("reset_illegal", illegal_o, 1'b0);
        check("reset_tag", tag_o, 5'h0);
        check("reset_in_ready", in_ready_o, 1'b1);
        rst_n = 1'b1;

        ready_mode = 0;
        send(I_CNT,  32'hF0F0_0001, 32'h0, 32'h0, 5'd7);
        send(I_EXT,  32'h0000_0F80, 32'h0, 32'h0, 5'd1);
        send(I_EXTU, 32'h0000_0F80, 32'h0, 32'h0, 5'd2);
        send(I_INS,  32'h0000_000F, 32'h0, 32'h0, 5'd3);
        send(I_BCLR, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd4);
        send(I_FF1,  32'h0,         32'h0, 32'h0, 5'd5);
        send(I_FL1,  32'h0,         32'h0, 32'h0, 5'd6);
        send(I_CLB,  32'h0,         32'h0, 32'h0, 5'd8);
        send(I_FF1,  32'h0001_0000, 32'h0, 32'h0, 5'd9);
        send(I_FL1,  32'h0001_0000, 32'h0, 32'h0, 5'd10);
        send(I_CLB,  32'h0001_0000, 32'h0, 32'h0, 5'd11);
        send(I_ROR,  32'h0000_0001, 32'h1, 32'h0, 5'd12);
        send(I_BAD,  32'h1234_5678, 32'h9, 32'h0, 5'd13);
        drain();

        ready_mode = 2;
        for (int i = 0; i < 8; i++) send(rand_instr(), rand_val(), $urandom(), $urandom(), 5'(i));
        drain();

        ready_mode = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(rand_instr(), rand_val(), $urandom(), $urandom(), 5'($urandom()));
        end
        drain();

        ready_mode = 0;
        for (int i = 0; i < 60; i++) send(rand_instr(), rand_val(), $urandom(), $urandom(), 5'($urandom()));
        drain();

        // Flush with two ops in flight and a third presented in the same cycle.
        ready_mode = 3;
        idle(1);
        send(I_CNT, 32'hFFFF_0000, 32'h0, 32'h0, 5'd20);
        send(I_ROR, 32'hABCD_0000, 32'h4, 32'h0, 5'd21);
        @(negedge clk);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        instr_i    = I_CNT;
        #1;
        check("flush_in_ready", in_ready_o, 1'b0);
        sb.delete();
        @(negedge clk);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        #2;
        check("flush_out_valid", out_valid_o, 1'b0);
        ready_mode = 0;
        idle(6);
        check("flush_no_output", 64'(sb.size()), 0);

        // Asynchronous reset in the middle of a cycle with ops in flight.
        ready_mode = 3;
        send(I_CNT, 32'h0000_00FF, 32'h0, 32'h0, 5'd22);
        send(I_FL1, 32'h0000_00FF, 32'h0, 32'h0, 5'd23);
        @(negedge clk);
        in_valid_i = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_result", result_o, 32'h0);
        check("rst_illegal", illegal_o, 1'b0);
        check("rst_tag", tag_o, 5'h0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        ready_mode = 0;
        idle(5);
        send(I_CNT, 32'hF0F0_0001, 32'h0, 32'h0, 5'd30);
        drain();
        check("final_empty", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
